// File: rtl/sl_tx_scheduler.sv
// Round-robin front end that shares one SL_transmitter among NUM_REQ requesters:
// caches the last config written and tracks each send through to completion or timeout.
module sl_tx_scheduler #(
   parameter int NUM_REQ       = 2,
   parameter int START_TIMEOUT = 16,
   parameter int DONE_TIMEOUT  = 65535
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [32*NUM_REQ-1:0]  req_data,
   input  logic [6*NUM_REQ-1:0]   req_len,
   input  logic [3*NUM_REQ-1:0]   req_freq,
   output logic [NUM_REQ-1:0]     done,
   output logic                   cfg_err,
   output logic                   timeout_err,
   output logic                   busy,
   output logic [31:0]            tx_data_a,
   output logic                   tx_send_imm,
   output logic [9:0]             tx_wr_config_w,
   output logic                   tx_wr_config_enable,
   input  logic                   tx_send_in_process
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_CONFIG     = 3'd1,
      S_SEND       = 3'd2,
      S_WAIT_START = 3'd3,
      S_WAIT_DONE  = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic [IW-1:0]        rr_ptr_q, rr_ptr_d, gnt_q, gnt_d;
   logic [31:0]          data_q, data_d;
   logic [8:0]           cfg_q, cfg_d, cur_cfg_q, cur_cfg_d;
   logic                 cfg_valid_q, cfg_valid_d;
   logic [15:0]          cnt_q, cnt_d;
   logic [NUM_REQ-1:0]   done_q, done_d;
   logic                 cfg_err_q, cfg_err_d, timeout_q, timeout_d, busy_q, busy_d;
   logic [31:0]          tx_data_q, tx_data_d;
   logic                 send_imm_q, send_imm_d, wr_cfg_en_q, wr_cfg_en_d;
   logic [9:0]           wr_cfg_w_q, wr_cfg_w_d;

   logic                 any_s, legal_s;
   logic [IW-1:0]        pick_s;
   logic [31:0]          sel_data_s;
   logic [5:0]           sel_len_s;
   logic [2:0]           sel_freq_s;
   logic [15:0]          cnt_inc_s;

   function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int off);
      int sum;
      sum = int'(base) + off;
      sum = (sum >= NUM_REQ) ? sum - NUM_REQ : sum;
      return IW'(sum);
   endfunction

   // Lowest offset from rr_ptr wins, so iterate downward and let the last hit stand.
   always_comb begin
      any_s  = 1'b0;
      pick_s = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[rr_idx(rr_ptr_q, i)]) begin
            any_s  = 1'b1;
            pick_s = rr_idx(rr_ptr_q, i);
         end else begin
            any_s  = any_s;
         end
      end
   end

   assign sel_data_s = req_data[32*pick_s +: 32];
   assign sel_len_s  = req_len[6*pick_s +: 6];
   assign sel_freq_s = req_freq[3*pick_s +: 3];
   assign legal_s    = !sel_len_s[0] && (sel_len_s >= 6'd8) && (sel_len_s <= 6'd32)
                       && (sel_freq_s <= 3'd5);
   assign cnt_inc_s  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
   assign req_ready  = (state_q == S_IDLE && any_s && !rst)
                       ? (NUM_REQ'(1) << pick_s) : '0;

   // Next-state and registered-output computation.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      gnt_d       = gnt_q;
      data_d      = data_q;
      cfg_d       = cfg_q;
      cur_cfg_d   = cur_cfg_q;
      cfg_valid_d = cfg_valid_q;
      cnt_d       = cnt_q;
      done_d      = '0;
      cfg_err_d   = 1'b0;
      timeout_d   = 1'b0;
      tx_data_d   = 32'd0;
      send_imm_d  = 1'b0;
      wr_cfg_en_d = 1'b0;
      wr_cfg_w_d  = 10'd0;
      case (state_q)
         S_IDLE: begin
            if (any_s) begin
               rr_ptr_d = rr_idx(pick_s, 1);
               gnt_d    = pick_s;
               data_d   = sel_data_s;
               cfg_d    = {sel_freq_s, sel_len_s};
               if (!legal_s) begin
                  cfg_err_d = 1'b1;
               end else if (cfg_valid_q && ({sel_freq_s, sel_len_s} == cur_cfg_q)) begin
                  state_d    = S_SEND;
                  send_imm_d = 1'b1;
                  tx_data_d  = sel_data_s;
               end else begin
                  state_d     = S_CONFIG;
                  wr_cfg_en_d = 1'b1;
                  wr_cfg_w_d  = {sel_freq_s, 1'b0, sel_len_s};
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CONFIG: begin
            cur_cfg_d   = cfg_q;
            cfg_valid_d = 1'b1;
            state_d     = S_SEND;
            send_imm_d  = 1'b1;
            tx_data_d   = data_q;
         end
         S_SEND: begin
            // Counter holds cycles elapsed since the send strobe.
            cnt_d   = 16'd1;
            state_d = S_WAIT_START;
         end
         S_WAIT_START: begin
            if (tx_send_in_process) begin
               cnt_d   = 16'd0;
               state_d = S_WAIT_DONE;
            end else begin
               cnt_d = cnt_inc_s;
               if (cnt_inc_s >= 16'(START_TIMEOUT)) begin
                  timeout_d   = 1'b1;
                  cfg_valid_d = 1'b0;
                  state_d     = S_IDLE;
               end else begin
                  state_d = S_WAIT_START;
               end
            end
         end
         S_WAIT_DONE: begin
            if (!tx_send_in_process) begin
               done_d  = NUM_REQ'(1) << gnt_q;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_inc_s;
               if (cnt_inc_s >= 16'(DONE_TIMEOUT)) begin
                  timeout_d   = 1'b1;
                  cfg_valid_d = 1'b0;
                  state_d     = S_IDLE;
               end else begin
                  state_d = S_WAIT_DONE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         rr_ptr_q    <= '0;
         gnt_q       <= '0;
         data_q      <= 32'd0;
         cfg_q       <= 9'd0;
         cur_cfg_q   <= 9'd0;
         cfg_valid_q <= 1'b0;
         cnt_q       <= 16'd0;
         done_q      <= '0;
         cfg_err_q   <= 1'b0;
         timeout_q   <= 1'b0;
         busy_q      <= 1'b0;
         tx_data_q   <= 32'd0;
         send_imm_q  <= 1'b0;
         wr_cfg_en_q <= 1'b0;
         wr_cfg_w_q  <= 10'd0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         gnt_q       <= gnt_d;
         data_q      <= data_d;
         cfg_q       <= cfg_d;
         cur_cfg_q   <= cur_cfg_d;
         cfg_valid_q <= cfg_valid_d;
         cnt_q       <= cnt_d;
         done_q      <= done_d;
         cfg_err_q   <= cfg_err_d;
         timeout_q   <= timeout_d;
         busy_q      <= busy_d;
         tx_data_q   <= tx_data_d;
         send_imm_q  <= send_imm_d;
         wr_cfg_en_q <= wr_cfg_en_d;
         wr_cfg_w_q  <= wr_cfg_w_d;
      end
   end

   assign done                = done_q;
   assign cfg_err             = cfg_err_q;
   assign timeout_err         = timeout_q;
   assign busy                = busy_q;
   assign tx_data_a           = tx_data_q;
   assign tx_send_imm         = send_imm_q;
   assign tx_wr_config_w      = wr_cfg_w_q;
   assign tx_wr_config_enable = wr_cfg_en_q;

endmodule

// File: tb/tb_sl_tx_scheduler.sv
// Scoreboard bench for sl_tx_scheduler: requesters and a transmitter model feed an
// observed-event queue, each scenario task compares it against its expected-event queue.
module tb_sl_tx_scheduler;

   localparam int NR = 2;
   localparam int ST = 16;
   localparam int DT = 65535;
   localparam int H  = 4;

   localparam int K_RDY = 0, K_CFG = 1, K_SEND = 2, K_DONE = 3, K_CERR = 4, K_TO = 5;

   typedef struct { logic [31:0] data; logic [5:0] len; logic [2:0] freq; } req_t;
   typedef struct { int cyc; int kind; logic [31:0] val; } ev_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [NR-1:0]   req_valid, req_ready, done;
   logic [32*NR-1:0] req_data;
   logic [6*NR-1:0] req_len;
   logic [3*NR-1:0] req_freq;
   logic            cfg_err, timeout_err, busy, tx_send_imm, tx_wr_config_enable, sip;
   logic [31:0]     tx_data_a;
   logic [9:0]      tx_wr_config_w;
   logic [50:0]     outs;

   req_t pend0[$], pend1[$];
   ev_t  exp_q[$], obs_q[$];
   int   cyc = 0;
   bit   acc0 = 1'b0, acc1 = 1'b0, sip_en = 1'b1;
   int   start_dly = 0, busy_left = 0;
   int   n_checks = 0, n_fail = 0;

   always #5 clk = ~clk;

   sl_tx_scheduler #(.NUM_REQ(NR), .START_TIMEOUT(ST), .DONE_TIMEOUT(DT)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_data(req_data), .req_len(req_len), .req_freq(req_freq), .done(done),
      .cfg_err(cfg_err), .timeout_err(timeout_err), .busy(busy), .tx_data_a(tx_data_a),
      .tx_send_imm(tx_send_imm), .tx_wr_config_w(tx_wr_config_w),
      .tx_wr_config_enable(tx_wr_config_enable), .tx_send_in_process(sip)
   );

   assign outs = {req_ready, done, cfg_err, timeout_err, busy, tx_data_a, tx_send_imm,
                  tx_wr_config_w, tx_wr_config_enable};

   function automatic req_t mk(input logic [31:0] d, input logic [5:0] l, input logic [2:0] f);
      req_t r;
      r.data = d; r.len = l; r.freq = f;
      return r;
   endfunction

   function automatic logic [31:0] cw(input logic [5:0] l, input logic [2:0] f);
      return {22'd0, f, 1'b0, l};
   endfunction

   function automatic void expect_ev(input int c, input int k, input logic [31:0] v);
      exp_q.push_back('{c, k, v});
   endfunction

   // Requesters, transmitter model and output monitor.
   initial begin
      req_valid = '0; req_data = '0; req_len = '0; req_freq = '0; sip = 1'b0;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (acc0) begin acc0 = 1'b0; if (pend0.size() > 0) pend0.delete(0); end
         if (acc1) begin acc1 = 1'b0; if (pend1.size() > 0) pend1.delete(0); end
         if (pend0.size() > 0) begin
            req_valid[0] = 1'b1; req_data[31:0] = pend0[0].data;
            req_len[5:0] = pend0[0].len; req_freq[2:0] = pend0[0].freq;
         end else req_valid[0] = 1'b0;
         if (pend1.size() > 0) begin
            req_valid[1] = 1'b1; req_data[63:32] = pend1[0].data;
            req_len[11:6] = pend1[0].len; req_freq[5:3] = pend1[0].freq;
         end else req_valid[1] = 1'b0;
         if (tx_send_imm && sip_en) start_dly = 2;
         else if (start_dly > 0) begin
            start_dly--;
            if (start_dly == 0) begin sip = 1'b1; busy_left = H; end
         end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) sip = 1'b0;
         end
         @(negedge clk);
         if (req_ready != '0) obs_q.push_back('{cyc, K_RDY, 32'(req_ready)});
         if (tx_wr_config_enable) obs_q.push_back('{cyc, K_CFG, 32'(tx_wr_config_w)});
         if (tx_send_imm) obs_q.push_back('{cyc, K_SEND, tx_data_a});
         if (done != '0) obs_q.push_back('{cyc, K_DONE, 32'(done)});
         if (cfg_err) obs_q.push_back('{cyc, K_CERR, 32'd1});
         if (timeout_err) obs_q.push_back('{cyc, K_TO, 32'd1});
         acc0 = acc0 | req_ready[0];
         acc1 = acc1 | req_ready[1];
      end
   end

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (outs !== 51'd0) begin
         n_fail++; $display("FAIL reset_outs: got %h, expected 0", outs);
      end
      #1 rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (outs !== 51'd0) begin
         n_fail++; $display("FAIL idle_outs: got %h, expected 0", outs);
      end
   endtask

   task automatic test_first_grant();
      ev_t e, o; int t;
      #1; obs_q.delete(); t = cyc + 1;
      pend0.push_back(mk(32'h0000A5A5, 6'd16, 3'd2));
      expect_ev(t, K_RDY, 32'd1);
      expect_ev(t + 1, K_CFG, cw(6'd16, 3'd2));
      expect_ev(t + 2, K_SEND, 32'h0000A5A5);
      expect_ev(t + 9, K_DONE, 32'd1);
      repeat (2) @(negedge clk);
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_grant: got %b, expected 1", busy); end
      repeat (12) @(negedge clk);
      #1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '{-1, -1, 32'd0};
         n_checks++;
         if (o.kind !== e.kind || o.val !== e.val || o.cyc !== e.cyc) begin
            n_fail++;
            $display("FAIL first_grant: got kind=%0d val=%h cyc=%0d, expected kind=%0d val=%h cyc=%0d",
                     o.kind, o.val, o.cyc, e.kind, e.val, e.cyc);
         end
      end
      n_checks++;
      if (obs_q.size() !== 0) begin
         n_fail++; $display("FAIL first_grant_extra: got %0d events, expected 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_cached_config();
      ev_t e, o; int t;
      obs_q.delete(); t = cyc + 1;
      pend0.push_back(mk(32'h12345678, 6'd16, 3'd2));
      expect_ev(t, K_RDY, 32'd1);
      expect_ev(t + 1, K_SEND, 32'h12345678);
      expect_ev(t + 8, K_DONE, 32'd1);
      repeat (12) @(negedge clk);
      #1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '{-1, -1, 32'd0};
         n_checks++;
         if (o.kind !== e.kind || o.val !== e.val || o.cyc !== e.cyc) begin
            n_fail++;
            $display("FAIL cached_config: got kind=%0d val=%h cyc=%0d, expected kind=%0d val=%h cyc=%0d",
                     o.kind, o.val, o.cyc, e.kind, e.val, e.cyc);
         end
      end
      n_checks++;
      if (obs_q.size() !== 0) begin
         n_fail++; $display("FAIL cached_config_extra: got %0d events, expected 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_round_robin();
      ev_t e, o; int t0, t1, t2, t3;
      rst = 1'b1;
      @(negedge clk);
      #1 rst = 1'b0;
      obs_q.delete(); t0 = cyc + 1;
      pend0.push_back(mk(32'hA0A0A0A0, 6'd16, 3'd2));
      pend0.push_back(mk(32'hA1A1A1A1, 6'd16, 3'd2));
      pend1.push_back(mk(32'hB0B0B0B0, 6'd16, 3'd2));
      pend1.push_back(mk(32'hB1B1B1B1, 6'd16, 3'd2));
      t1 = t0 + 9; t2 = t1 + 8; t3 = t2 + 8;
      expect_ev(t0, K_RDY, 32'd1);
      expect_ev(t0 + 1, K_CFG, cw(6'd16, 3'd2));
      expect_ev(t0 + 2, K_SEND, 32'hA0A0A0A0);
      expect_ev(t1, K_RDY, 32'd2);
      expect_ev(t1, K_DONE, 32'd1);
      expect_ev(t1 + 1, K_SEND, 32'hB0B0B0B0);
      expect_ev(t2, K_RDY, 32'd1);
      expect_ev(t2, K_DONE, 32'd2);
      expect_ev(t2 + 1, K_SEND, 32'hA1A1A1A1);
      expect_ev(t3, K_RDY, 32'd2);
      expect_ev(t3, K_DONE, 32'd1);
      expect_ev(t3 + 1, K_SEND, 32'hB1B1B1B1);
      expect_ev(t3 + 8, K_DONE, 32'd2);
      repeat (40) @(negedge clk);
      #1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '{-1, -1, 32'd0};
         n_checks++;
         if (o.kind !== e.kind || o.val !== e.val || o.cyc !== e.cyc) begin
            n_fail++;
            $display("FAIL round_robin: got kind=%0d val=%h cyc=%0d, expected kind=%0d val=%h cyc=%0d",
                     o.kind, o.val, o.cyc, e.kind, e.val, e.cyc);
         end
      end
      n_checks++;
      if (obs_q.size() !== 0) begin
         n_fail++; $display("FAIL round_robin_extra: got %0d events, expected 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_illegal();
      ev_t e, o; int t;
      req_t bad[3];
      bad[0] = mk(32'h11111111, 6'd9, 3'd2);
      bad[1] = mk(32'h22222222, 6'd34, 3'd2);
      bad[2] = mk(32'h33333333, 6'd16, 3'd6);
      obs_q.delete();
      for (int i = 0; i < 3; i++) begin
         t = cyc + 1;
         pend0.push_back(bad[i]);
         expect_ev(t, K_RDY, 32'd1);
         expect_ev(t + 1, K_CERR, 32'd1);
         repeat (5) @(negedge clk);
         #1;
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '{-1, -1, 32'd0};
         n_checks++;
         if (o.kind !== e.kind || o.val !== e.val || o.cyc !== e.cyc) begin
            n_fail++;
            $display("FAIL illegal: got kind=%0d val=%h cyc=%0d, expected kind=%0d val=%h cyc=%0d",
                     o.kind, o.val, o.cyc, e.kind, e.val, e.cyc);
         end
      end
      n_checks++;
      if (obs_q.size() !== 0) begin
         n_fail++; $display("FAIL illegal_extra: got %0d events, expected 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_start_timeout();
      ev_t e, o; int t;
      obs_q.delete(); sip_en = 1'b0; t = cyc + 1;
      pend0.push_back(mk(32'h00C0FFEE, 6'd16, 3'd2));
      expect_ev(t, K_RDY, 32'd1);
      expect_ev(t + 1, K_SEND, 32'h00C0FFEE);
      expect_ev(t + 1 + ST, K_TO, 32'd1);
      repeat (22) @(negedge clk);
      #1;
      sip_en = 1'b1; t = cyc + 1;
      pend0.push_back(mk(32'h0000BEEF, 6'd16, 3'd2));
      expect_ev(t, K_RDY, 32'd1);
      expect_ev(t + 1, K_CFG, cw(6'd16, 3'd2));
      expect_ev(t + 2, K_SEND, 32'h0000BEEF);
      expect_ev(t + 9, K_DONE, 32'd1);
      repeat (12) @(negedge clk);
      #1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '{-1, -1, 32'd0};
         n_checks++;
         if (o.kind !== e.kind || o.val !== e.val || o.cyc !== e.cyc) begin
            n_fail++;
            $display("FAIL start_timeout: got kind=%0d val=%h cyc=%0d, expected kind=%0d val=%h cyc=%0d",
                     o.kind, o.val, o.cyc, e.kind, e.val, e.cyc);
         end
      end
      n_checks++;
      if (obs_q.size() !== 0) begin
         n_fail++; $display("FAIL start_timeout_extra: got %0d events, expected 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_mid_reset();
      ev_t e, o; int t;
      obs_q.delete(); t = cyc + 1;
      pend0.push_back(mk(32'h5555AAAA, 6'd16, 3'd2));
      expect_ev(t, K_RDY, 32'd1);
      expect_ev(t + 1, K_SEND, 32'h5555AAAA);
      repeat (5) @(negedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if (outs !== 51'd0) begin
         n_fail++; $display("FAIL mid_reset_outs: got %h, expected 0", outs);
      end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy: got %b, expected 0", busy); end
      #1 rst = 1'b0;
      repeat (8) @(negedge clk);
      #1;
      t = cyc + 1;
      pend0.push_back(mk(32'h0F0F0F0F, 6'd16, 3'd2));
      expect_ev(t, K_RDY, 32'd1);
      expect_ev(t + 1, K_CFG, cw(6'd16, 3'd2));
      expect_ev(t + 2, K_SEND, 32'h0F0F0F0F);
      expect_ev(t + 9, K_DONE, 32'd1);
      repeat (12) @(negedge clk);
      #1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '{-1, -1, 32'd0};
         n_checks++;
         if (o.kind !== e.kind || o.val !== e.val || o.cyc !== e.cyc) begin
            n_fail++;
            $display("FAIL mid_reset: got kind=%0d val=%h cyc=%0d, expected kind=%0d val=%h cyc=%0d",
                     o.kind, o.val, o.cyc, e.kind, e.val, e.cyc);
         end
      end
      n_checks++;
      if (obs_q.size() !== 0) begin
         n_fail++; $display("FAIL mid_reset_extra: got %0d events, expected 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   initial begin
      test_reset();
      test_first_grant();
      test_cached_config();
      test_round_robin();
      test_illegal();
      test_start_timeout();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
